// File: rtl/address_bus_sequencer_if.sv
// Bus-side signal bundle for address_bus_sequencer.
//
// master : the requester side (CPU datapath sources, select, start, write
//          qualifier) plus the memory ready line; it drives the request and
//          observes the registered bus outputs.
// slave  : the sequencer itself.
//
// Signals
//   src_addr   NUM_SRC*ADDR_WIDTH  packed sources, source i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   addr_busx  SEL_WIDTH           source select, sampled only with start
//   start      1                   request a bus cycle
//   we_in      1                   write qualifier, sampled with start
//   mem_ready  1                   memory/IO ready
//   addr       ADDR_WIDTH          registered bus address
//   addr_valid 1                   high throughout ACCESS
//   we         1                   registered write enable, valid with addr_valid
//   busy       1                   high in ACCESS
//   done       1                   one-cycle completion pulse
//   bus_err    1                   one-cycle timeout pulse coincident with done
interface address_bus_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned SEL_WIDTH  = 2
);
    logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr;
    logic [SEL_WIDTH-1:0]          addr_busx;
    logic                          start;
    logic                          we_in;
    logic                          mem_ready;
    logic [ADDR_WIDTH-1:0]         addr;
    logic                          addr_valid;
    logic                          we;
    logic                          busy;
    logic                          done;
    logic                          bus_err;

    modport master (
        output src_addr, addr_busx, start, we_in, mem_ready,
        input  addr, addr_valid, we, busy, done, bus_err
    );

    modport slave (
        input  src_addr, addr_busx, start, we_in, mem_ready,
        output addr, addr_valid, we, busy, done, bus_err
    );
endinterface

// File: rtl/address_bus_sequencer.sv
// Address bus sequencer: picks one of NUM_SRC address sources, registers it
// and runs one memory bus cycle (IDLE -> ACCESS -> COMPLETE) with a
// programmable number of wait states and a mem_ready handshake.
//
// Ports
//   clk_i   system clock, rising edge
//   rst_i   synchronous, active-high reset
//   bus_io  address_bus_sequencer_if.slave (sources, select, start, we_in,
//           mem_ready in; addr, addr_valid, we, busy, done, bus_err out)
//
// Optional feature: define ADDR_BUS_TIMEOUT_EN to abort an ACCESS after
// TIMEOUT_CYCLES cycles of mem_ready low (counted once the wait states have
// elapsed); the abort completes with done and bus_err pulsing together.
// Without the macro bus_err is tied low and ACCESS waits for mem_ready forever.
module address_bus_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned SEL_WIDTH      = 2,
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                   clk_i,
    input logic                   rst_i,
    address_bus_sequencer_if.slave bus_io
);

    if (NUM_SRC < 2 || (2 ** SEL_WIDTH) < NUM_SRC || WAIT_STATES > 15 ||
        TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("address_bus_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StComplete
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    we_q, we_d;
    logic [3:0]              wait_q, wait_d;

`ifdef ADDR_BUS_TIMEOUT_EN
    localparam int unsigned ToWidth = $clog2(TIMEOUT_CYCLES + 1);

    logic [ToWidth-1:0]      to_q, to_d;
    logic                    err_q, err_d;
`endif

    // Source mux; an out-of-range select matches no source and yields 0.
    always_comb begin
        sel_addr = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus_io.addr_busx == SEL_WIDTH'(i)) begin
                sel_addr = bus_io.src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wait_d  = wait_q;
`ifdef ADDR_BUS_TIMEOUT_EN
        to_d    = to_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle, StComplete: begin
                if (bus_io.start) begin
                    addr_d  = sel_addr;
                    we_d    = bus_io.we_in;
                    wait_d  = 4'(WAIT_STATES);
`ifdef ADDR_BUS_TIMEOUT_EN
                    to_d    = '0;
`endif
                    state_d = StAccess;
                end else begin
                    state_d = StIdle;
                end
            end
            StAccess: begin
                // mem_ready is deliberately ignored until the wait states run out.
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (bus_io.mem_ready) begin
                    state_d = StComplete;
`ifdef ADDR_BUS_TIMEOUT_EN
                end else if (to_q == ToWidth'(TIMEOUT_CYCLES - 1)) begin
                    // This edge is the TIMEOUT_CYCLES-th low-ready cycle.
                    state_d = StComplete;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + ToWidth'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wait_q  <= '0;
`ifdef ADDR_BUS_TIMEOUT_EN
            to_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wait_q  <= wait_d;
`ifdef ADDR_BUS_TIMEOUT_EN
            to_q    <= to_d;
            err_q   <= err_d;
`endif
        end
    end

    // All outputs come straight from registers (state decode or latched values).
    assign bus_io.addr       = addr_q;
    assign bus_io.addr_valid = (state_q == StAccess);
    assign bus_io.busy       = (state_q == StAccess);
    assign bus_io.we         = we_q & (state_q == StAccess);
    assign bus_io.done       = (state_q == StComplete);
`ifdef ADDR_BUS_TIMEOUT_EN
    // err_q is only ever set on the edge that enters StComplete.
    assign bus_io.bus_err    = err_q;
`else
    assign bus_io.bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_address_bus_sequencer.sv
// Randomized bench for address_bus_sequencer. Stimulus for the whole run is
// generated up front; a transaction-level model then works out, for every
// accepted request, which edge completes it (wait states, first ready edge,
// optional timeout, or an aborting reset) and fills per-cycle expected outputs.
module tb_address_bus_sequencer;

    localparam int unsigned AW = 16;
    localparam int unsigned NS = 3;   // fewer sources than selects: exercises select 3 -> 0
    localparam int unsigned SW = 2;
    localparam int unsigned W  = 3;
    localparam int unsigned TO = 16;
    localparam int          N  = 800;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    address_bus_sequencer_if #(.ADDR_WIDTH(AW), .NUM_SRC(NS), .SEL_WIDTH(SW)) bus ();

    address_bus_sequencer #(
        .ADDR_WIDTH    (AW),
        .NUM_SRC       (NS),
        .SEL_WIDTH     (SW),
        .WAIT_STATES   (W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    // Stimulus applied before edge k.
    bit                 s_rst   [N];
    bit                 s_start [N];
    bit                 s_we    [N];
    bit                 s_rdy   [N];
    logic [SW-1:0]      s_sel   [N];
    logic [NS*AW-1:0]   s_src   [N];

    // Expected outputs just after edge k.
    logic [AW-1:0]      e_addr  [N];
    bit                 e_valid [N];
    bit                 e_we    [N];
    bit                 e_done  [N];
    bit                 e_err   [N];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input int cyc, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void fill_out(int k, logic [AW-1:0] a, bit v, bit w, bit d, bit er);
        e_addr[k]  = a;
        e_valid[k] = v;
        e_we[k]    = w;
        e_done[k]  = d;
        e_err[k]   = er;
    endfunction

    function automatic void gen_stimulus();
        int burst = 0;
        for (int i = 0; i < N; i++) begin
            s_rst[i]   = (i < 2) || ($urandom_range(0, 79) == 0);
            s_start[i] = (i < 2) || ($urandom_range(0, 1) == 1);
            s_we[i]    = ($urandom_range(0, 1) == 1);
            s_sel[i]   = SW'($urandom_range(0, 3));
            s_src[i]   = (NS*AW)'({$urandom(), $urandom()});
            if (burst > 0) begin
                s_rdy[i] = 1'b0;
                burst--;
            end else if ($urandom_range(0, 39) == 0) begin
                s_rdy[i] = 1'b0;
                burst    = 20;   // long enough to trip the timeout when enabled
            end else begin
                s_rdy[i] = ($urandom_range(0, 3) != 0);
            end
        end
    endfunction

    function automatic void build_model();
        int            k = 0;
        logic [AW-1:0] last = '0;
        while (k < N) begin
            if (s_rst[k]) begin
                last = '0;
                fill_out(k, '0, 0, 0, 0, 0);
                k++;
            end else if (!s_start[k]) begin
                fill_out(k, last, 0, 0, 0, 0);
                k++;
            end else begin
                int c   = N;
                int low = 0;
                int j;
                bit err = 1'b0;
                bit wr  = s_we[k];
                int sel = int'(s_sel[k]);
                last = (sel < int'(NS)) ? s_src[k][sel*AW +: AW] : '0;
                // Ready is only looked at once W edges of waiting have passed.
                for (int e = k + 1 + int'(W); e < N; e++) begin
                    if (s_rdy[e]) begin
                        c = e;
                        break;
                    end
                    low++;
`ifdef ADDR_BUS_TIMEOUT_EN
                    if (low == int'(TO)) begin
                        c   = e;
                        err = 1'b1;
                        break;
                    end
`endif
                end
                fill_out(k, last, 1, wr, 0, 0);
                j = k + 1;
                while (j < N && j <= c) begin
                    if (s_rst[j]) break;   // reset aborts: outer loop handles edge j
                    if (j == c) fill_out(j, last, 0, 0, 1, err);
                    else        fill_out(j, last, 1, wr, 0, 0);
                    j++;
                end
                k = j;
            end
        end
    endfunction

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.we_in     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.addr_busx = '0;
        bus.src_addr  = '0;

        gen_stimulus();
        build_model();

        for (int k = 0; k < N; k++) begin
            rst           = s_rst[k];
            bus.start     = s_start[k];
            bus.we_in     = s_we[k];
            bus.mem_ready = s_rdy[k];
            bus.addr_busx = s_sel[k];
            bus.src_addr  = s_src[k];
            @(posedge clk);
            #1;
            check_eq("addr",       k, 32'(bus.addr),       32'(e_addr[k]));
            check_eq("addr_valid", k, 32'(bus.addr_valid), 32'(e_valid[k]));
            check_eq("busy",       k, 32'(bus.busy),       32'(e_valid[k]));
            check_eq("we",         k, 32'(bus.we),         32'(e_we[k]));
            check_eq("done",       k, 32'(bus.done),       32'(e_done[k]));
            check_eq("bus_err",    k, 32'(bus.bus_err),    32'(e_err[k]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
